// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants for the shift sequencer: register mode codes and FSM state encoding.
package shift_seq_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROL  = 2'b01;
    localparam logic [1:0] MODE_ROR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/status bundle of the shift sequencer; state is exported for observation only.
interface shift_seq_ctrl_if #(
    parameter int W    = 4,
    parameter int CNTW = 4,
    parameter int DIVW = 8
);
    import shift_seq_ctrl_pkg::*;

    // start is a level request sampled only while busy=0; there is no ready
    // side and no queuing, a request seen while busy is simply dropped.
    logic            start;
    logic [W-1:0]    pattern;
    logic            dir;
    logic [CNTW-1:0] steps;
    logic [DIVW-1:0] div;
    logic            pingpong;
    logic            abort;
    logic            busy;
    logic            done;
    logic [1:0]      s;
    logic [W-1:0]    q;
    state_t          state;

    modport master (
        output start, pattern, dir, steps, div, pingpong, abort,
        input  busy, done, s, q, state
    );

    modport slave (
        input  start, pattern, dir, steps, div, pingpong, abort,
        output busy, done, s, q, state
    );

endinterface

// File: rtl/shift_seq_ctrl_rot_reg.sv
// W-bit register with hold / rotate-left / rotate-right / parallel-load modes.
module rot_reg
    import shift_seq_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   s,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (s)
                MODE_ROL:  q <= {q[W-2:0], q[W-1]};
                MODE_ROR:  q <= {q[0], q[W-1:1]};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load / rotate / optional ping-pong sequencer driving a rot_reg, paced by a prescaler.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int W    = 4,
    parameter int CNTW = 4,
    parameter int DIVW = 8
) (
    input logic            clk,
    input logic            rst,
    shift_seq_ctrl_if.slave bus
);

    state_t          state, state_nx;
    logic [W-1:0]    pat_l;
    logic            dir_l, dir_nx;
    logic            pp_l;
    logic [CNTW-1:0] steps_l;
    logic [DIVW-1:0] div_l;
    logic [CNTW-1:0] step_cnt, step_nx;
    logic [DIVW-1:0] pre_cnt, pre_nx;
    logic            leg, leg_nx;
    logic [1:0]      mode;
    logic            done_c;
    logic [W-1:0]    q_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pat_l    <= '0;
            dir_l    <= 1'b0;
            pp_l     <= 1'b0;
            steps_l  <= '0;
            div_l    <= '0;
            step_cnt <= '0;
            pre_cnt  <= '0;
            leg      <= 1'b0;
        end else begin
            state    <= state_nx;
            step_cnt <= step_nx;
            pre_cnt  <= pre_nx;
            leg      <= leg_nx;
            if (state == ST_IDLE && bus.start) begin
                pat_l   <= bus.pattern;
                dir_l   <= bus.dir;
                pp_l    <= bus.pingpong;
                steps_l <= bus.steps;
                div_l   <= bus.div;
            end else begin
                dir_l <= dir_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step_cnt;
        pre_nx   = pre_cnt;
        leg_nx   = leg;
        dir_nx   = dir_l;
        mode     = MODE_HOLD;
        done_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_LOAD;
                    leg_nx   = 1'b0;
                    step_nx  = '0;
                    pre_nx   = '0;
                end
            end
            ST_LOAD: begin
                mode   = MODE_LOAD;
                pre_nx = '0;
                if (steps_l == '0)     state_nx = ST_DONE;
                else if (div_l == '0)  state_nx = ST_SHIFT;
                else                   state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // Terminal-count compare before incrementing so div at its max never wraps early.
                if (pre_cnt == div_l - DIVW'(1)) state_nx = ST_SHIFT;
                else                             pre_nx = pre_cnt + DIVW'(1);
            end
            ST_SHIFT: begin
                mode   = dir_l ? MODE_ROR : MODE_ROL;
                pre_nx = '0;
                if (step_cnt != steps_l - CNTW'(1)) begin
                    step_nx  = step_cnt + CNTW'(1);
                    state_nx = (div_l != '0) ? ST_WAIT : ST_SHIFT;
                end else if (pp_l && !leg) begin
                    leg_nx   = 1'b1;
                    dir_nx   = ~dir_l;
                    step_nx  = '0;
                    state_nx = (div_l != '0) ? ST_WAIT : ST_SHIFT;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Abort freezes the register and drops the sequence without a done pulse.
        if (bus.abort && state != ST_IDLE) begin
            state_nx = ST_IDLE;
            mode     = MODE_HOLD;
            done_c   = 1'b0;
        end
    end

    rot_reg #(.W(W)) u_rot_reg (
        .clk (clk),
        .rst (rst),
        .s   (mode),
        .d   (pat_l),
        .q   (q_int)
    );

    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = done_c;
    assign bus.s     = mode;
    assign bus.q     = q_int;
    assign bus.state = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl against a cycle-trace model built from the sequencing rules.
module tb_shift_seq_ctrl;

    localparam int W    = 4;
    localparam int CNTW = 4;
    localparam int DIVW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.W(W), .CNTW(CNTW), .DIVW(DIVW)) bus ();

    shift_seq_ctrl #(.W(W), .CNTW(CNTW), .DIVW(DIVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0]   model_q;
    logic [W+3:0]   exp_q[$];   // per-cycle {busy, done, s, q}

    function automatic logic [W-1:0] rot(input logic [W-1:0] v, input logic right);
        if (right) return (v >> 1) | (v << (W-1));
        return (v << 1) | (v >> (W-1));
    endfunction

    // Expected cycle-by-cycle outputs from the LOAD cycle through the DONE cycle.
    function automatic void build_trace(input logic [W-1:0] pat, input logic d0,
                                        input int n_steps, input int n_div, input logic pp);
        logic d;
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 2'b11, model_q});
        model_q = pat;
        d = d0;
        if (n_steps != 0) begin
            for (int leg = 0; leg < (pp ? 2 : 1); leg++) begin
                for (int k = 0; k < n_steps; k++) begin
                    for (int c = 0; c < n_div; c++) exp_q.push_back({1'b1, 1'b0, 2'b00, model_q});
                    exp_q.push_back({1'b1, 1'b0, (d ? 2'b10 : 2'b01), model_q});
                    model_q = rot(model_q, d);
                end
                d = ~d;
            end
        end
        exp_q.push_back({1'b1, 1'b1, 2'b00, model_q});
    endfunction

    function automatic logic [W+3:0] obs();
        return {bus.busy, bus.done, bus.s, bus.q};
    endfunction

    // Returns at the negedge inside the LOAD cycle with post-latch inputs scrambled.
    task automatic start_seq(input logic [W-1:0] pat, input logic d, input int n_steps,
                             input int n_div, input logic pp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.pattern  = pat;
        bus.dir      = d;
        bus.steps    = CNTW'(n_steps);
        bus.div      = DIVW'(n_div);
        bus.pingpong = pp;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.pattern  = W'($urandom);
        bus.dir      = 1'($urandom);
        bus.steps    = CNTW'($urandom);
        bus.div      = DIVW'($urandom);
        bus.pingpong = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.pattern = 4'b1111;
        bus.steps = 4'd3;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        model_q = '0;
        checks++;
        if (obs() !== {1'b0, 1'b0, 2'b00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: got busy/done/s/q=%b expected %b", obs(), {1'b0, 1'b0, 2'b00, 4'b0000});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.q !== 4'b0000) begin
                errors++;
                $display("FAIL reset_no_start: got busy=%b q=%b expected busy=0 q=0000", bus.busy, bus.q);
            end
        end
    endtask

    task automatic test_sequences();
        logic [W-1:0] pat;
        logic d, pp;
        int n_steps, n_div, cyc;
        for (int t = 0; t < 30; t++) begin
            case (t)
                0: begin pat = 4'b0001; d = 0; n_steps = 3;  n_div = 0;   pp = 0; end
                1: begin pat = 4'b1000; d = 1; n_steps = 2;  n_div = 2;   pp = 0; end
                2: begin pat = 4'b0011; d = 0; n_steps = 2;  n_div = 0;   pp = 1; end
                3: begin pat = 4'b0110; d = 1; n_steps = 15; n_div = 0;   pp = 1; end
                4: begin pat = 4'b1001; d = 0; n_steps = 1;  n_div = 255; pp = 0; end
                default: begin
                    pat = W'($urandom); d = 1'($urandom); pp = 1'($urandom);
                    n_steps = $urandom_range(0, 6); n_div = $urandom_range(0, 3);
                end
            endcase
            build_trace(pat, d, n_steps, n_div, pp);
            start_seq(pat, d, n_steps, n_div, pp);
            cyc = 0;
            while (exp_q.size() != 0) begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL seq%0d cyc%0d: got busy/done/s/q=%b expected %b", t, cyc, obs(), e);
                end
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL seq%0d_idle: got busy=%b done=%b expected 0 0", t, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] pat;
        pat = 4'b0101;
        start_seq(pat, 1'b0, 5, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        checks++;
        if (bus.busy !== 1'b1 || bus.s !== 2'b00) begin
            errors++;
            $display("FAIL abort_wait2: got busy=%b s=%b expected busy=1 s=00", bus.busy, bus.s);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        model_q = pat;
        repeat (3) begin
            checks++;
            if (obs() !== {1'b0, 1'b0, 2'b00, pat}) begin
                errors++;
                $display("FAIL abort_idle: got busy/done/s/q=%b expected %b", obs(), {1'b0, 1'b0, 2'b00, pat});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle_abort();
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.q !== model_q) begin
            errors++;
            $display("FAIL abort_in_idle: got busy=%b q=%b expected busy=0 q=%b", bus.busy, bus.q, model_q);
        end
        // start and abort together: start wins, abort then kills the LOAD before it loads.
        bus.start = 1'b1;
        bus.pattern = ~model_q;
        bus.steps = 4'd2;
        bus.div = '0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.s !== 2'b00) begin
            errors++;
            $display("FAIL start_beats_abort: got busy=%b s=%b expected busy=1 s=00", bus.busy, bus.s);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (obs() !== {1'b0, 1'b0, 2'b00, model_q}) begin
            errors++;
            $display("FAIL abort_in_load: got busy/done/s/q=%b expected %b", obs(), {1'b0, 1'b0, 2'b00, model_q});
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] pat;
        int cyc;
        pat = 4'b1100;
        build_trace(pat, 1'b1, 2, 1, 1'b0);
        start_seq(pat, 1'b1, 2, 1, 1'b0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            logic [W+3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ignored_start cyc%0d: got busy/done/s/q=%b expected %b", cyc, obs(), e);
            end
            if (cyc == 1) begin
                bus.start = 1'b1;
                bus.steps = 4'd9;
                bus.pattern = 4'b0111;
            end else begin
                bus.start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        start_seq(4'b0001, 1'b0, 3, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.s !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_shift: got s=%b expected 01", bus.s);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q = '0;
        checks++;
        if (obs() !== {1'b0, 1'b0, 2'b00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid: got busy/done/s/q=%b expected %b", obs(), {1'b0, 1'b0, 2'b00, 4'b0000});
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_zero_steps();
        start_seq(4'b1010, 1'b0, 0, 5, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.s !== 2'b11 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_steps_load: got busy=%b s=%b done=%b expected 1 11 0", bus.busy, bus.s, bus.done);
        end
        @(negedge clk);
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'b00, 4'b1010}) begin
            errors++;
            $display("FAIL zero_steps_done: got busy/done/s/q=%b expected %b", obs(), {1'b1, 1'b1, 2'b00, 4'b1010});
        end
        @(negedge clk);
        model_q = 4'b1010;
        checks++;
        if (obs() !== {1'b0, 1'b0, 2'b00, 4'b1010}) begin
            errors++;
            $display("FAIL zero_steps_idle: got busy/done/s/q=%b expected %b", obs(), {1'b0, 1'b0, 2'b00, 4'b1010});
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.dir      = 1'b0;
        bus.steps    = '0;
        bus.div      = '0;
        bus.pingpong = 1'b0;
        bus.abort    = 1'b0;
        model_q      = '0;
        test_reset();
        test_sequences();
        test_abort();
        test_idle_abort();
        test_ignored_start();
        test_reset_mid();
        test_zero_steps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
